// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter for the CPU core: exec/fetch fixed-priority arbitration
// plus a sprite-DMA engine that halts the CPU and copies one page to OAM_PORT.
module mem_bus_arbiter #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] OAM_PORT   = 16'h2004
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    input  logic                  exec_req,
    input  logic                  exec_we,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [REG_WIDTH-1:0]  exec_wdata,
    output logic                  exec_gnt,
    input  logic                  dma_start,
    input  logic [7:0]            dma_page,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  rdata_valid,
    output logic                  cpu_halt,
    output logic                  dma_busy,
    output logic [1:0]            owner,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DMA_ALIGN = 2'd1;
    localparam logic [1:0] DMA_READ  = 2'd2;
    localparam logic [1:0] DMA_WRITE = 2'd3;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_EXEC  = 2'd2;
    localparam logic [1:0] OWN_DMA   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  parity_q;
    logic                  align_extra_q, align_extra_d;
    logic [7:0]            page_q, page_d;
    logic [7:0]            idx_q, idx_d;
    logic [REG_WIDTH-1:0]  buf_q, buf_d;
    logic [REG_WIDTH-1:0]  rdata_q;
    logic                  rvalid_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  rd_access;

    // Bus-side outputs; everything is forced quiet while reset_n is low.
    always_comb begin
        fetch_gnt = 1'b0;
        exec_gnt  = 1'b0;
        owner     = OWN_NONE;
        mem_addr  = mem_addr_q;
        mem_we    = 1'b0;
        mem_wdata = buf_q;
        cpu_halt  = 1'b0;
        rd_access = 1'b0;
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    if (exec_req) begin
                        exec_gnt  = 1'b1;
                        owner     = OWN_EXEC;
                        mem_addr  = exec_addr;
                        mem_we    = exec_we;
                        mem_wdata = exec_wdata;
                        rd_access = ~exec_we;
                    end else if (fetch_req) begin
                        fetch_gnt = 1'b1;
                        owner     = OWN_FETCH;
                        mem_addr  = fetch_addr;
                        rd_access = 1'b1;
                    end
                end
                DMA_ALIGN: begin
                    owner    = OWN_DMA;
                    cpu_halt = 1'b1;
                end
                DMA_READ: begin
                    owner    = OWN_DMA;
                    cpu_halt = 1'b1;
                    mem_addr = ADDR_WIDTH'({page_q, idx_q});
                end
                default: begin
                    owner    = OWN_DMA;
                    cpu_halt = 1'b1;
                    mem_addr = OAM_PORT;
                    mem_we   = 1'b1;
                end
            endcase
        end
    end

    assign dma_busy    = cpu_halt;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign dbg_state   = state_q;

    // DMA sequencing; a strobe outside IDLE never reaches this decode.
    always_comb begin
        state_d       = state_q;
        align_extra_d = align_extra_q;
        page_d        = page_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        case (state_q)
            IDLE: begin
                if (dma_start) begin
                    page_d        = dma_page;
                    align_extra_d = parity_q;
                    state_d       = DMA_ALIGN;
                end
            end
            DMA_ALIGN: begin
                if (align_extra_q) begin
                    align_extra_d = 1'b0;
                end else begin
                    state_d = DMA_READ;
                end
            end
            DMA_READ: begin
                buf_d   = mem_rdata;
                state_d = DMA_WRITE;
            end
            DMA_WRITE: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? IDLE : DMA_READ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            parity_q      <= 1'b0;
            align_extra_q <= 1'b0;
            page_q        <= 8'h00;
            idx_q         <= 8'h00;
            buf_q         <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            parity_q      <= ~parity_q;
            align_extra_q <= align_extra_d;
            page_q        <= page_d;
            idx_q         <= idx_d;
            buf_q         <= buf_d;
            rvalid_q      <= rd_access;
            mem_addr_q    <= mem_addr;
            if (rd_access) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule
